// File: rtl/muldiv_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_seq_ctrl
//  Brief    : Multi-cycle sequencer for unsigned WIDTHxWIDTH multiply
//             (shift-add) and WIDTH/WIDTH divide (restoring). It time-shares
//             one external ripple adder/subtractor and returns the result
//             as hi/lo in the MULTU/DIVU layout.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_ctr,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_co
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Iteration counter value of the final iteration
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    // Operation selector encoding
    localparam logic c_op_mul = 1'b0;
    localparam logic c_op_div = 1'b1;

    // Sequencer states
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_op;
    // Holds the multiplicand for a multiply and the divisor for a divide;
    // only one of them is ever needed at a time.
    logic [WIDTH-1:0]   r_operand;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_dbz;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic               w_idle;
    logic               w_run;
    logic               w_accept;
    logic               w_accept_dbz;
    logic               w_last_iter;
    logic [WIDTH-1:0]   w_rem_shift;
    logic               w_div_ok;
    logic [WIDTH-1:0]   w_mul_hi_nxt;
    logic [WIDTH-1:0]   w_mul_lo_nxt;
    logic [WIDTH-1:0]   w_div_hi_nxt;
    logic [WIDTH-1:0]   w_div_lo_nxt;

    assign w_idle       = (r_state == c_st_idle);
    assign w_run        = (r_state == c_st_run);
    assign w_accept     = w_idle & start;
    assign w_accept_dbz = w_accept & (op == c_op_div) & (opb == '0);
    assign w_last_iter  = (r_cnt == c_cnt_last);

    // Partial remainder shifted left by one, pulling in the next dividend bit.
    // Its true MSB (r_hi[WIDTH-1]) falls off here and is folded back in via
    // w_div_ok: when it is set the shifted remainder already exceeds any
    // divisor, so the subtraction must be accepted regardless of carry.
    assign w_rem_shift  = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    assign w_div_ok     = r_hi[WIDTH-1] | add_co;

    // Multiply step: the (WIDTH*2+1)-bit {co, sum, lo} shifted right by one
    assign w_mul_hi_nxt = {add_co, add_s[WIDTH-1:1]};
    assign w_mul_lo_nxt = {add_s[0], r_lo[WIDTH-1:1]};

    // Divide step: keep the difference only when it is non-negative
    assign w_div_hi_nxt = w_div_ok ? add_s : w_rem_shift;
    assign w_div_lo_nxt = {r_lo[WIDTH-2:0], w_div_ok};

    // ------------------------------------------------------------------------
    // Adder operand steering; the shared adder sees zeros outside RUN
    // ------------------------------------------------------------------------
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_ctr = 1'b0;
        if (w_run) begin
            if (r_op == c_op_mul) begin
                add_a   = r_hi;
                add_b   = r_lo[0] ? r_operand : '0;
                add_ctr = 1'b0;
            end else begin
                add_a   = w_rem_shift;
                add_b   = r_operand;
                add_ctr = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer state and iteration counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_cnt   <= '0;
                        r_state <= w_accept_dbz ? c_st_done : c_st_run;
                    end
                end
                c_st_run: begin
                    if (w_last_iter) begin
                        r_state <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Operation and operand capture, only on an accepted start
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= c_op_mul;
            r_operand <= '0;
        end else if (w_accept) begin
            r_op      <= op;
            r_operand <= (op == c_op_div) ? opb : opa;
        end
    end

    // ------------------------------------------------------------------------
    // hi/lo result registers and divide-by-zero flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            if (w_accept_dbz) begin
                // Divide by zero returns dividend as remainder, all-ones quotient
                r_hi  <= opa;
                r_lo  <= '1;
                r_dbz <= 1'b1;
            end else if (op == c_op_mul) begin
                // Multiplier sits in lo and is consumed LSB first
                r_hi  <= '0;
                r_lo  <= opb;
                r_dbz <= 1'b0;
            end else begin
                // Dividend sits in lo and is shifted into hi MSB first
                r_hi  <= '0;
                r_lo  <= opa;
                r_dbz <= 1'b0;
            end
        end else if (w_run) begin
            if (r_op == c_op_mul) begin
                r_hi <= w_mul_hi_nxt;
                r_lo <= w_mul_lo_nxt;
            end else begin
                r_hi <= w_div_hi_nxt;
                r_lo <= w_div_lo_nxt;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy        = w_run;
    assign done        = (r_state == c_st_done);
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_seq_ctrl
//  Brief    : Directed self-checking bench for muldiv_seq_ctrl, including a
//             behavioural model of the shared ripple adder/subtractor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_ctr;
    logic [31:0] add_s;
    logic        add_co;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // External adder: S/Co = A + (B ^ {32{ctr}}) + ctr
    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b ^ {32{add_ctr}}} + {32'd0, add_ctr};

    muldiv_seq_ctrl #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .opa         (opa),
        .opb         (opb),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_ctr     (add_ctr),
        .add_s       (add_s),
        .add_co      (add_co)
    );

    // Advance one edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operation for one accept edge (E0), then scramble operands
    task automatic launch(input logic o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        opa   = a;
        opb   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        opa   = $urandom;
        opb   = $urandom;
    endtask

    // Called just after E0; cycles counts edges from E0 inclusive until done
    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles      = 1;
        busy_cycles = 0;
        while (done !== 1'b1 && cycles < 100) begin
            if (busy === 1'b1) busy_cycles++;
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctrl: got busy/done/dbz=%b required 000", {busy, done, div_by_zero});
        end
        total++;
        if ({hi, lo} !== 64'd0) begin
            bad++;
            $display("FAIL reset_hilo: got %h required 0", {hi, lo});
        end
        total++;
        if ({add_a, add_b, add_ctr} !== 65'd0) begin
            bad++;
            $display("FAIL reset_adder: got a=%h b=%h ctr=%b required all 0", add_a, add_b, add_ctr);
        end
    endtask

    task automatic test_mul_basic();
        int cyc, bcyc;
        launch(1'b0, 32'd7, 32'd6);
        wait_done(cyc, bcyc);
        total++;
        if (cyc !== 33) begin
            bad++;
            $display("FAIL mul_latency: got %0d required 33", cyc);
        end
        total++;
        if (bcyc !== 32) begin
            bad++;
            $display("FAIL mul_busy_cycles: got %0d required 32", bcyc);
        end
        total++;
        if (hi !== 32'd0 || lo !== 32'd42) begin
            bad++;
            $display("FAIL mul_7x6: got hi=%h lo=%h required hi=0 lo=2a", hi, lo);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mul_done_pulse: got done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_mul_carry();
        int cyc, bcyc;
        launch(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(cyc, bcyc);
        total++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            bad++;
            $display("FAIL mul_max: got hi=%h lo=%h required fffffffe 00000001", hi, lo);
        end
        tick();
    endtask

    task automatic test_div_basic();
        int cyc, bcyc;
        launch(1'b1, 32'd100, 32'd7);
        // First iteration: remainder 0, divisor 7, subtract mode
        total++;
        if (add_a !== 32'd0 || add_b !== 32'd7 || add_ctr !== 1'b1) begin
            bad++;
            $display("FAIL div_adder_drive: got a=%h b=%h ctr=%b required 0 7 1", add_a, add_b, add_ctr);
        end
        wait_done(cyc, bcyc);
        total++;
        if (cyc !== 33) begin
            bad++;
            $display("FAIL div_latency: got %0d required 33", cyc);
        end
        total++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            bad++;
            $display("FAIL div_100_7: got hi=%h lo=%h required hi=2 lo=e", hi, lo);
        end
        tick();
        total++;
        if (add_b !== 32'd0 || add_ctr !== 1'b0 || add_a !== 32'd0) begin
            bad++;
            $display("FAIL idle_adder: got a=%h b=%h ctr=%b required 0 0 0", add_a, add_b, add_ctr);
        end
    endtask

    task automatic test_div_msb();
        int cyc, bcyc;
        launch(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE);
        wait_done(cyc, bcyc);
        total++;
        if (lo !== 32'd1 || hi !== 32'd1) begin
            bad++;
            $display("FAIL div_max: got hi=%h lo=%h required hi=1 lo=1", hi, lo);
        end
        tick();
    endtask

    task automatic test_div_zero();
        int cyc, bcyc;
        launch(1'b1, 32'd5, 32'd0);
        wait_done(cyc, bcyc);
        total++;
        if (cyc !== 1 || bcyc !== 0) begin
            bad++;
            $display("FAIL dbz_latency: got cycles=%0d busy=%0d required 1 0", cyc, bcyc);
        end
        total++;
        if (div_by_zero !== 1'b1 || hi !== 32'd5 || lo !== 32'hFFFFFFFF) begin
            bad++;
            $display("FAIL dbz_result: got dbz=%b hi=%h lo=%h required 1 5 ffffffff", div_by_zero, hi, lo);
        end
        tick();
        total++;
        if (done !== 1'b0 || div_by_zero !== 1'b1 || hi !== 32'd5) begin
            bad++;
            $display("FAIL dbz_hold: got done=%b dbz=%b hi=%h required 0 1 5", done, div_by_zero, hi);
        end
        launch(1'b0, 32'd2, 32'd3);
        total++;
        if (div_by_zero !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL dbz_clear: got dbz=%b busy=%b required 0 1", div_by_zero, busy);
        end
        wait_done(cyc, bcyc);
        total++;
        if (lo !== 32'd6 || hi !== 32'd0) begin
            bad++;
            $display("FAIL mul_2x3: got hi=%h lo=%h required 0 6", hi, lo);
        end
        tick();
    endtask

    task automatic test_ignored_start();
        int n;
        int pulses;
        launch(1'b0, 32'd1000, 32'd3000);
        n = 1;
        repeat (4) begin
            tick();
            n++;
        end
        // Conflicting request mid-run: a divide by zero that must not take effect
        op    = 1'b1;
        opa   = 32'hDEADBEEF;
        opb   = 32'd0;
        start = 1'b1;
        tick();
        n++;
        start = 1'b0;
        op    = 1'b0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (n !== 33) begin
            bad++;
            $display("FAIL ign_latency: got %0d required 33", n);
        end
        total++;
        if (hi !== 32'd0 || lo !== 32'd3000000 || div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL ign_run_result: got hi=%h lo=%h dbz=%b required 0 2dc6c0 0", hi, lo, div_by_zero);
        end
        // Request while in DONE
        op    = 1'b0;
        opa   = 32'd9;
        opb   = 32'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL ign_done_start: got busy=%b done=%b required 0 0", busy, done);
        end
        pulses = 0;
        repeat (40) begin
            if (done === 1'b1 || busy === 1'b1) pulses++;
            tick();
        end
        total++;
        if (pulses !== 0 || lo !== 32'd3000000 || hi !== 32'd0) begin
            bad++;
            $display("FAIL ign_after: got extra=%0d hi=%h lo=%h required 0 0 2dc6c0", pulses, hi, lo);
        end
    endtask

    task automatic test_rst_abort();
        int cyc, bcyc;
        int pulses;
        launch(1'b0, 32'h12345678, 32'h9ABCDEF1);
        repeat (9) tick();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre_busy: got %b required 1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({busy, done, div_by_zero, add_ctr} !== 4'b0000 || {hi, lo, add_a, add_b} !== 128'd0) begin
            bad++;
            $display("FAIL abort_outputs: got busy=%b done=%b dbz=%b hi=%h lo=%h a=%h b=%h ctr=%b required all 0",
                     busy, done, div_by_zero, hi, lo, add_a, add_b, add_ctr);
        end
        pulses = 0;
        repeat (40) begin
            if (done === 1'b1 || busy === 1'b1) pulses++;
            tick();
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL abort_no_done: got %0d active cycles required 0", pulses);
        end
        launch(1'b0, 32'd3, 32'd4);
        wait_done(cyc, bcyc);
        total++;
        if (lo !== 32'd12 || hi !== 32'd0 || cyc !== 33) begin
            bad++;
            $display("FAIL abort_recover: got hi=%h lo=%h cycles=%0d required 0 c 33", hi, lo, cyc);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_mul_carry();
        test_div_basic();
        test_div_msb();
        test_div_zero();
        test_ignored_start();
        test_rst_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
